crack_scheduler: RTL and testbench

//  Key-space scheduler for the ARC4 brute-force cracker. Splits the key range
//  0..KEY_MAX into fixed-size chunks and hands them round-robin to NUM_CORES

---
 rtl/crack_scheduler_if.sv | 38 +++
 rtl/crack_scheduler.sv | 198 +++++++++++++++++++
 tb/tb_crack_scheduler.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/crack_scheduler_if.sv
// ---------------------------------------------------------------------------
// crack_scheduler_if
// Groups the signals between the key-space scheduler, the board-level
// control FSM and the crack cores.
//   en/rdy/key/key_valid          : control FSM handshake and result
//   core_rdy/core_en/core_base    : per-core chunk dispatch
//   core_done/core_found/core_key : per-core chunk completion and hit report
//   core_abort                    : broadcast stop to all cores
// Modports:
//   slave  : the scheduler's view
//   master : the control FSM / core side (used by the testbench)
// ---------------------------------------------------------------------------
interface crack_scheduler_if #(
  parameter int NUM_CORES = 2,
  parameter int KEY_W     = 24
);
  logic                       en;
  logic                       rdy;
  logic [KEY_W-1:0]           key;
  logic                       key_valid;
  logic [NUM_CORES-1:0]       core_rdy;
  logic [NUM_CORES-1:0]       core_en;
  logic [NUM_CORES*KEY_W-1:0] core_base;
  logic [NUM_CORES-1:0]       core_done;
  logic [NUM_CORES-1:0]       core_found;
  logic [NUM_CORES*KEY_W-1:0] core_key;
  logic                       core_abort;

  modport slave (
    input  en, core_rdy, core_done, core_found, core_key,
    output rdy, key, key_valid, core_en, core_base, core_abort
  );

  modport master (
    output en, core_rdy, core_done, core_found, core_key,
    input  rdy, key, key_valid, core_en, core_base, core_abort
  );
endinterface

// File: rtl/crack_scheduler.sv
// ---------------------------------------------------------------------------
// crack_scheduler
// Key-space scheduler for the ARC4 brute-force cracker. The key range
// 0..KEY_MAX is cut into CHUNK-sized pieces that are handed round-robin to
// NUM_CORES crack cores. The first reported hit stops every core and the key
// is latched; if the space runs out with no hit the search ends with
// key_valid=0.
// Ports:
//   clk, rst       : system clock, synchronous active-high reset
//   bus (slave)    : control handshake en/rdy/key/key_valid and the per-core
//                    core_rdy/core_en/core_base/core_done/core_found/
//                    core_key/core_abort signals
//   chunks_done    : (only with CRACK_SCHED_PROGRESS_EN) number of chunks
//                    completed in the current/last search, saturating
// Optional feature macro: CRACK_SCHED_PROGRESS_EN
// ---------------------------------------------------------------------------
module crack_scheduler #(
  parameter int          NUM_CORES = 2,
  parameter int          KEY_W     = 24,
  parameter int unsigned CHUNK     = 32'h1000,
  parameter int unsigned KEY_MAX   = 2**KEY_W - 1
) (
  input  logic clk,
  input  logic rst,
`ifdef CRACK_SCHED_PROGRESS_EN
  output logic [KEY_W:0] chunks_done,
`endif
  crack_scheduler_if.slave bus
);

  // Extra headroom bit so next_base + CHUNK never wraps in the compare.
  localparam int EW = KEY_W + 2;
  localparam int BW = KEY_W + 1;
  localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int OW = $clog2(NUM_CORES + 1);

  localparam logic [EW-1:0] CHUNK_E = EW'(CHUNK);
  localparam logic [EW-1:0] KMAX_E  = EW'(KEY_MAX);
  localparam logic [BW-1:0] CHUNK_B = BW'(CHUNK);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_ABORT
  } state_t;

  state_t state_q, state_d;

  logic [BW-1:0]              next_base_q;
  logic                       exhausted_q;
  logic [OW-1:0]              outstanding_q;
  logic [PW-1:0]              rr_ptr_q;
  logic [NUM_CORES-1:0]       core_en_q;
  logic [NUM_CORES*KEY_W-1:0] core_base_q;
  logic [KEY_W-1:0]           key_q;
  logic                       key_valid_q;

  logic                 start;
  logic                 hit;
  logic [KEY_W-1:0]     hit_key;
  logic [OW-1:0]        done_cnt;
  logic [NUM_CORES-1:0] eligible;
  logic                 pick_vld;
  logic [PW-1:0]        pick_idx;
  logic                 grant_vld;
  logic [PW-1:0]        grant_idx;
  logic [NUM_CORES-1:0] grant_oh;
  int                   idx;

  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    hit       = 1'b0;
    hit_key   = '0;
    done_cnt  = '0;
    pick_vld  = 1'b0;
    pick_idx  = '0;
    grant_vld = 1'b0;
    grant_idx = '0;
    grant_oh  = '0;
    idx       = 0;

    // Descending scan so the lowest reporting index wins.
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (bus.core_done[i] && bus.core_found[i]) begin
        hit     = 1'b1;
        hit_key = bus.core_key[i*KEY_W +: KEY_W];
      end
    end

    for (int i = 0; i < NUM_CORES; i++) begin
      done_cnt = done_cnt + OW'(bus.core_done[i]);
    end

    // A core granted last cycle still shows core_rdy=1 this cycle; mask it.
    eligible = bus.core_rdy & ~core_en_q;

    for (int k = 0; k < NUM_CORES; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      if (!pick_vld && eligible[idx]) begin
        pick_vld = 1'b1;
        pick_idx = PW'(idx);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (bus.en) begin
          start   = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (hit) begin
          state_d = S_ABORT;
        end else if (exhausted_q && outstanding_q == '0) begin
          state_d = S_IDLE;
        end else if (!exhausted_q && pick_vld) begin
          grant_vld = 1'b1;
          grant_idx = pick_idx;
        end
      end
      S_ABORT: begin
        if (&bus.core_rdy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    grant_oh[grant_idx] = grant_vld;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      next_base_q   <= '0;
      exhausted_q   <= 1'b0;
      outstanding_q <= '0;
      rr_ptr_q      <= '0;
      core_en_q     <= '0;
      core_base_q   <= '0;
      key_q         <= '0;
      key_valid_q   <= 1'b0;
    end else begin
      core_en_q <= grant_oh;
      if (start) begin
        key_q         <= '0;
        key_valid_q   <= 1'b0;
        next_base_q   <= '0;
        outstanding_q <= '0;
        exhausted_q   <= 1'b0;
      end
      if (state_q == S_RUN) begin
        outstanding_q <= outstanding_q + OW'(grant_vld) - done_cnt;
        if (grant_vld) begin
          core_base_q[grant_idx*KEY_W +: KEY_W] <= next_base_q[KEY_W-1:0];
          next_base_q <= next_base_q + CHUNK_B;
          if (grant_idx == PW'(NUM_CORES - 1)) rr_ptr_q <= '0;
          else                                 rr_ptr_q <= grant_idx + 1'b1;
          if ({1'b0, next_base_q} + CHUNK_E > KMAX_E) exhausted_q <= 1'b1;
        end
        if (hit) begin
          key_q       <= hit_key;
          key_valid_q <= 1'b1;
        end
      end
    end
  end

`ifdef CRACK_SCHED_PROGRESS_EN
  logic [KEY_W+1:0] chunks_sum;

  always_comb begin
    chunks_sum = {1'b0, chunks_done} + (KEY_W+2)'(done_cnt);
  end

  always_ff @(posedge clk) begin
    if (rst || start) begin
      chunks_done <= '0;
    end else if (state_q == S_RUN) begin
      if (chunks_sum[KEY_W+1]) chunks_done <= '1;
      else                     chunks_done <= chunks_sum[KEY_W:0];
    end
  end
`endif

  assign bus.rdy        = (state_q == S_IDLE);
  assign bus.core_abort = (state_q == S_ABORT);
  assign bus.key        = key_q;
  assign bus.key_valid  = key_valid_q;
  assign bus.core_en    = core_en_q;
  assign bus.core_base  = core_base_q;

endmodule

// File: tb/tb_crack_scheduler.sv
// ---------------------------------------------------------------------------
// tb_crack_scheduler
// Directed bench for crack_scheduler with two mock crack cores
// (KEY_W=8, CHUNK=16, KEY_MAX=255). Each mock core accepts a chunk on
// core_en, stays busy for a programmable number of cycles, then pulses
// core_done and reports a hit if its planted key lies in its chunk.
// ---------------------------------------------------------------------------
module tb_crack_scheduler;
  localparam int NC = 2;
  localparam int KW = 8;
  localparam int CH = 16;
  localparam int KM = 255;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  crack_scheduler_if #(.NUM_CORES(NC), .KEY_W(KW)) bus ();

`ifdef CRACK_SCHED_PROGRESS_EN
  logic [KW:0] chunks_done;
`endif

  crack_scheduler #(
    .NUM_CORES(NC),
    .KEY_W    (KW),
    .CHUNK    (CH),
    .KEY_MAX  (KM)
  ) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef CRACK_SCHED_PROGRESS_EN
    .chunks_done(chunks_done),
`endif
    .bus        (bus)
  );

  int total = 0;
  int bad   = 0;

  // Mock cores
  int            lat [NC];
  logic [NC-1:0] plant_en = '0;
  logic [KW-1:0] plant_key [NC];
  logic          hold1 = 1'b0;
  logic [NC-1:0] c_busy = '0;
  logic [NC-1:0] c_done = '0;
  logic [NC-1:0] c_found = '0;
  logic [KW-1:0] c_base [NC];
  logic [KW-1:0] c_key [NC];
  int            c_cnt [NC];

  always @(posedge clk) begin
    for (int i = 0; i < NC; i++) begin
      c_done[i]  <= 1'b0;
      c_found[i] <= 1'b0;
      if (rst || bus.core_abort) begin
        c_busy[i] <= 1'b0;
      end else if (bus.core_en[i] && !c_busy[i] && !(i == 1 && hold1)) begin
        c_busy[i] <= 1'b1;
        c_cnt[i]  <= lat[i] - 1;
        c_base[i] <= bus.core_base[i*KW +: KW];
      end else if (c_busy[i]) begin
        if (c_cnt[i] == 0) begin
          c_busy[i]  <= 1'b0;
          c_done[i]  <= 1'b1;
          c_found[i] <= plant_en[i] && (int'(plant_key[i]) >= int'(c_base[i])) &&
                        (int'(plant_key[i]) <= int'(c_base[i]) + CH - 1);
          c_key[i]   <= plant_key[i];
        end else begin
          c_cnt[i] <= c_cnt[i] - 1;
        end
      end
    end
  end

  assign bus.core_rdy   = ~c_busy & {~hold1, 1'b1};
  assign bus.core_done  = c_done;
  assign bus.core_found = c_found;
  assign bus.core_key   = {c_key[1], c_key[0]};

  // Dispatch / abort monitor
  int en_cores [$];
  int en_bases [$];
  int multi_en = 0;
  int abort_en = 0;
  int abort_seen = 0;
  int both_hit = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.core_en != '0) begin
        if ($countones(bus.core_en) > 1) multi_en++;
        for (int i = 0; i < NC; i++) begin
          if (bus.core_en[i]) begin
            en_cores.push_back(i);
            en_bases.push_back(int'(bus.core_base[i*KW +: KW]));
          end
        end
      end
      if (bus.core_abort) begin
        abort_seen++;
        if (bus.core_en != '0) abort_en++;
      end
      if (bus.core_done == 2'b11 && bus.core_found == 2'b11) both_hit++;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    bus.en = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    en_cores.delete();
    en_bases.delete();
    multi_en = 0;
    abort_en = 0;
    abort_seen = 0;
    both_hit = 0;
  endtask

  task automatic start_search();
    bus.en = 1'b1;
    @(posedge clk);
    #1 bus.en = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (bus.rdy) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s_timeout: rdy never returned (got 0, want 1)", name);
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total++; if (bus.rdy !== 1'b1) begin bad++; $display("FAIL rst_rdy: got %b want 1", bus.rdy); end
    total++; if (bus.key !== 8'h00) begin bad++; $display("FAIL rst_key: got %h want 00", bus.key); end
    total++; if (bus.key_valid !== 1'b0) begin bad++; $display("FAIL rst_key_valid: got %b want 0", bus.key_valid); end
    total++; if (bus.core_en !== 2'b00) begin bad++; $display("FAIL rst_core_en: got %b want 00", bus.core_en); end
    total++; if (bus.core_base !== 16'h0000) begin bad++; $display("FAIL rst_core_base: got %h want 0000", bus.core_base); end
    total++; if (bus.core_abort !== 1'b0) begin bad++; $display("FAIL rst_core_abort: got %b want 0", bus.core_abort); end
`ifdef CRACK_SCHED_PROGRESS_EN
    total++; if (chunks_done !== '0) begin bad++; $display("FAIL rst_chunks_done: got %0d want 0", chunks_done); end
`endif
  endtask

  task automatic test_dispatch_latency();
    do_reset();
    start_search();
    @(negedge clk);
    total++; if (bus.rdy !== 1'b0) begin bad++; $display("FAIL lat_rdy_low: got %b want 0", bus.rdy); end
    total++; if (bus.core_en !== 2'b00) begin bad++; $display("FAIL lat_cyc0_en: got %b want 00", bus.core_en); end
    @(negedge clk);
    total++; if (bus.core_en !== 2'b01) begin bad++; $display("FAIL lat_cyc1_en: got %b want 01", bus.core_en); end
    total++; if (bus.core_base[7:0] !== 8'h00) begin bad++; $display("FAIL lat_cyc1_base: got %h want 00", bus.core_base[7:0]); end
    @(negedge clk);
    total++; if (bus.core_en !== 2'b10) begin bad++; $display("FAIL lat_cyc2_en: got %b want 10", bus.core_en); end
    total++; if (bus.core_base[15:8] !== 8'h10) begin bad++; $display("FAIL lat_cyc2_base: got %h want 10", bus.core_base[15:8]); end
    wait_idle("lat");
  endtask

  task automatic test_exhaust();
    int seq_err = 0;
    do_reset();
    start_search();
    wait_idle("exh");
    for (int i = 0; i < en_bases.size(); i++)
      if (en_bases[i] != i * CH) seq_err++;
    total++; if (en_bases.size() != 16) begin bad++; $display("FAIL exh_count: got %0d want 16", en_bases.size()); end
    total++; if (seq_err != 0) begin bad++; $display("FAIL exh_base_seq: got %0d bad bases want 0", seq_err); end
    total++; if (en_bases.size() > 0 && en_bases[en_bases.size()-1] != 'hF0) begin
      bad++; $display("FAIL exh_last_base: got %h want f0", en_bases[en_bases.size()-1]); end
    total++; if (bus.key_valid !== 1'b0) begin bad++; $display("FAIL exh_key_valid: got %b want 0", bus.key_valid); end
    total++; if (multi_en != 0) begin bad++; $display("FAIL exh_one_en: got %0d multi-grant cycles want 0", multi_en); end
`ifdef CRACK_SCHED_PROGRESS_EN
    total++; if (chunks_done !== 9'd16) begin bad++; $display("FAIL exh_chunks_done: got %0d want 16", chunks_done); end
`endif
  endtask

  task automatic test_hit();
    do_reset();
    plant_en = 2'b11;
    plant_key[0] = 8'h5A;
    plant_key[1] = 8'h5A;
    start_search();
    wait_idle("hit");
    total++; if (bus.key_valid !== 1'b1) begin bad++; $display("FAIL hit_key_valid: got %b want 1", bus.key_valid); end
    total++; if (bus.key !== 8'h5A) begin bad++; $display("FAIL hit_key: got %h want 5a", bus.key); end
    total++; if (abort_seen == 0) begin bad++; $display("FAIL hit_abort_seen: got 0 abort cycles want >0"); end
    total++; if (abort_en != 0) begin bad++; $display("FAIL hit_en_in_abort: got %0d want 0", abort_en); end
    total++; if (bus.core_abort !== 1'b0) begin bad++; $display("FAIL hit_abort_clear: got %b want 0", bus.core_abort); end
    plant_en = 2'b00;
  endtask

  task automatic test_rdy_hold();
    int seq_err = 0;
    int core_err = 0;
    do_reset();
    hold1 = 1'b1;
    start_search();
    wait_idle("hold");
    for (int i = 0; i < en_bases.size(); i++) begin
      if (en_bases[i] != i * CH) seq_err++;
      if (en_cores[i] != 0) core_err++;
    end
    total++; if (en_bases.size() != 16) begin bad++; $display("FAIL hold_count: got %0d want 16", en_bases.size()); end
    total++; if (core_err != 0) begin bad++; $display("FAIL hold_core1_used: got %0d grants want 0", core_err); end
    total++; if (seq_err != 0) begin bad++; $display("FAIL hold_base_seq: got %0d bad bases want 0", seq_err); end
    hold1 = 1'b0;
  endtask

  task automatic test_double_hit();
    do_reset();
    lat[0] = 20;
    lat[1] = 19;
    plant_en = 2'b11;
    plant_key[0] = 8'h21;
    plant_key[1] = 8'h35;
    start_search();
    wait_idle("dbl");
    total++; if (both_hit == 0) begin bad++; $display("FAIL dbl_same_cycle: got 0 joint hits want >0"); end
    total++; if (bus.key !== 8'h21) begin bad++; $display("FAIL dbl_key: got %h want 21", bus.key); end
    total++; if (bus.key_valid !== 1'b1) begin bad++; $display("FAIL dbl_key_valid: got %b want 1", bus.key_valid); end
    plant_en = 2'b00;
    lat[0] = 20;
    lat[1] = 20;
  endtask

  task automatic test_rst_mid_run();
    do_reset();
    start_search();
    repeat (30) @(posedge clk);
    @(negedge clk);
    total++; if (bus.rdy !== 1'b0) begin bad++; $display("FAIL mid_running: got rdy %b want 0", bus.rdy); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++; if (bus.rdy !== 1'b1) begin bad++; $display("FAIL mid_rdy: got %b want 1", bus.rdy); end
    total++; if (bus.core_en !== 2'b00) begin bad++; $display("FAIL mid_core_en: got %b want 00", bus.core_en); end
    total++; if (bus.core_abort !== 1'b0) begin bad++; $display("FAIL mid_abort: got %b want 0", bus.core_abort); end
    total++; if (bus.key_valid !== 1'b0) begin bad++; $display("FAIL mid_key_valid: got %b want 0", bus.key_valid); end
`ifdef CRACK_SCHED_PROGRESS_EN
    total++; if (chunks_done !== '0) begin bad++; $display("FAIL mid_chunks_done: got %0d want 0", chunks_done); end
`endif
    rst = 1'b0;
  endtask

  initial begin
    lat[0] = 20;
    lat[1] = 20;
    plant_key[0] = '0;
    plant_key[1] = '0;
    bus.en = 1'b0;
    test_reset();
    test_dispatch_latency();
    test_exhaust();
    test_hit();
    test_reset();
    test_rdy_hold();
    test_double_hit();
    test_rst_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
